seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver_if.sv | 20 ++
 rtl/seg7_scan_driver.sv | 111 +++++++++++
 tb/tb_seg7_scan_driver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display value in, multiplexed seg/dig pins out
interface seg7_scan_driver_if;
  logic        enable;
  logic [15:0] bcd;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  modport master (
    output enable, bcd, dp_in, blank_lz,
    input  seg, dig, frame_done
  );

  modport slave (
    input  enable, bcd, dp_in, blank_lz,
    output seg, dig, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit seven-segment scanner with blanking gap
// Inputs are shadowed once per frame so a digit sequence is never torn.
module seg7_scan_driver #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYCLES   = 50,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave disp
);
  localparam int DIV    = CLK_HZ / SCAN_HZ;
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_CYCLES);

  logic [TICK_W-1:0] r_tick;
  logic [1:0]        r_idx;
  logic [15:0]       r_bcd;
  logic [3:0]        r_dp;
  logic              r_blz;
  logic              r_pending;
  logic              r_frame_done;
  logic [7:0]        r_seg;
  logic [3:0]        r_dig;

  logic       w_slot_end;
  logic       w_load;
  logic       w_lit;
  logic [3:0] w_digit;
  logic [3:0] w_lz;
  logic [6:0] w_glyph;
  logic [7:0] w_seg_on;
  logic [3:0] w_dig_on;

  always_comb begin
    w_slot_end = (r_tick == TICK_LAST);
    w_load     = r_pending || (w_slot_end && (r_idx == 2'd3));
    w_lit      = disp.enable && (r_tick >= TICK_BLANK);

    // w_lz[k]: digit k and everything to its left are zero
    w_lz[3] = (r_bcd[15:12] == 4'd0);
    w_lz[2] = w_lz[3] && (r_bcd[11:8] == 4'd0);
    w_lz[1] = w_lz[2] && (r_bcd[7:4] == 4'd0);
    w_lz[0] = 1'b0;

    case (r_idx)
      2'd0:    w_digit = r_bcd[3:0];
      2'd1:    w_digit = r_bcd[7:4];
      2'd2:    w_digit = r_bcd[11:8];
      default: w_digit = r_bcd[15:12];
    endcase

    case (w_digit)
      4'd0:    w_glyph = 7'h3F;
      4'd1:    w_glyph = 7'h06;
      4'd2:    w_glyph = 7'h5B;
      4'd3:    w_glyph = 7'h4F;
      4'd4:    w_glyph = 7'h66;
      4'd5:    w_glyph = 7'h6D;
      4'd6:    w_glyph = 7'h7D;
      4'd7:    w_glyph = 7'h07;
      4'd8:    w_glyph = 7'h7F;
      4'd9:    w_glyph = 7'h6F;
      default: w_glyph = 7'h40;
    endcase

    w_seg_on = 8'h00;
    w_dig_on = 4'h0;
    if (w_lit) begin
      w_dig_on = 4'b0001 << r_idx;
      w_seg_on = {r_dp[r_idx], (r_blz && w_lz[r_idx]) ? 7'h00 : w_glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick       <= '0;
      r_idx        <= 2'd0;
      r_bcd        <= 16'h0000;
      r_dp         <= 4'h0;
      r_blz        <= 1'b0;
      r_pending    <= 1'b1;
      r_frame_done <= 1'b0;
      r_seg        <= {8{SEG_ACTIVE_LOW}};
      r_dig        <= {4{DIG_ACTIVE_LOW}};
    end else begin
      r_pending    <= 1'b0;
      r_frame_done <= w_load;
      if (w_load) begin
        r_bcd <= disp.bcd;
        r_dp  <= disp.dp_in;
        r_blz <= disp.blank_lz;
      end
      if (w_slot_end) begin
        r_tick <= '0;
        r_idx  <= r_idx + 2'd1;
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
      r_seg <= w_seg_on ^ {8{SEG_ACTIVE_LOW}};
      r_dig <= w_dig_on ^ {4{DIG_ACTIVE_LOW}};
    end
  end

  assign disp.seg        = r_seg;
  assign disp.dig        = r_dig;
  assign disp.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - bench for seg7_scan_driver (DIV=10, BLANK=2)
module tb_seg7_scan_driver;
  localparam int BLANK = 2;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic            blz;
    logic            en;
    logic [3:0][7:0] seg;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[9];
  vec_t v9999;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  seg7_scan_driver_if disp();

  seg7_scan_driver #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .disp(disp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] bcd, input logic [3:0] dp, input logic blz,
                              input logic en, input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0);
    vec_t v;
    v.bcd = bcd; v.dp = dp; v.blz = blz; v.en = en;
    v.seg = {s3, s2, s1, s0};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    disp.bcd      = v.bcd;
    disp.dp_in    = v.dp;
    disp.blank_lz = v.blz;
    disp.enable   = v.en;
  endtask

  task automatic push_frame(input vec_t v);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 4'b0001 << i;
      exp_q.push_back({v.en ? ~d : 4'hF, v.seg[i]});
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!disp.frame_done && n < 100);
    chk("frame_done_timeout", disp.frame_done, 1);
  endtask

  // Called on the frame_done cycle; walks the following 40 cycles of one frame.
  task automatic check_frame(input int poke_k, input logic [15:0] poke_bcd);
    logic [11:0] cur = 12'hFFF;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k % 10 == BLANK) begin
        chk("scoreboard_underflow", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
      end
      if (k % 10 < BLANK)
        chk($sformatf("gap slot%0d c%0d", k / 10, k % 10), {disp.dig, disp.seg}, 12'hFFF);
      else
        chk($sformatf("slot%0d c%0d dig/seg", k / 10, k % 10), {disp.dig, disp.seg}, cur);
      chk($sformatf("frame_done k%0d", k), disp.frame_done, (k == 39));
      if (k == poke_k) disp.bcd = poke_bcd;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) chk("dig_onehot", ($countones(~disp.dig) <= 1), 1);
  end

  initial begin
    vecs[0] = mk(16'h1234, 4'h0, 1'b0, 1'b1, 8'hF9, 8'hA4, 8'hB0, 8'h99);
    vecs[1] = mk(16'h0050, 4'h0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h92, 8'hC0);
    vecs[2] = mk(16'h0050, 4'h0, 1'b0, 1'b1, 8'hC0, 8'hC0, 8'h92, 8'hC0);
    vecs[3] = mk(16'h0000, 4'h2, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h7F, 8'hC0);
    vecs[4] = mk(16'hA000, 4'h0, 1'b1, 1'b1, 8'hBF, 8'hC0, 8'hC0, 8'hC0);
    vecs[5] = mk(16'h8888, 4'hF, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[6] = mk(16'h0007, 4'h8, 1'b1, 1'b1, 8'h7F, 8'hFF, 8'hFF, 8'hF8);
    vecs[7] = mk(16'h1234, 4'h0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vecs[8] = mk(16'h0305, 4'h1, 1'b1, 1'b1, 8'hFF, 8'hB0, 8'hC0, 8'h12);
    v9999   = mk(16'h9999, 4'h0, 1'b0, 1'b1, 8'h90, 8'h90, 8'h90, 8'h90);

    drive(vecs[0]);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset seg", disp.seg, 8'hFF);
    chk("reset dig", disp.dig, 4'hF);
    chk("reset frame_done", disp.frame_done, 0);

    rst = 1'b0;
    @(negedge clk);
    chk("frame_done after release", disp.frame_done, 1);
    @(negedge clk);
    chk("first gap dig", disp.dig, 4'hF);
    chk("first frame_done low", disp.frame_done, 0);
    @(negedge clk);
    chk("first lit dig/seg", {disp.dig, disp.seg}, {4'hE, 8'h99});

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      push_frame(vecs[i]);
      wait_fd();
      check_frame(-1, 16'h0000);
    end

    // Input change mid-frame must not tear the frame in progress
    drive(vecs[0]);
    push_frame(vecs[0]);
    wait_fd();
    check_frame(15, 16'h9999);
    push_frame(v9999);
    check_frame(-1, 16'h0000);

    // Reset pulse at idx=2, tick=5
    drive(vecs[0]);
    wait_fd();
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort seg", disp.seg, 8'hFF);
    chk("abort dig", disp.dig, 4'hF);
    chk("abort frame_done", disp.frame_done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort reload frame_done", disp.frame_done, 1);
    @(negedge clk);
    chk("abort restart gap", disp.dig, 4'hF);
    @(negedge clk);
    chk("abort restart idx0", {disp.dig, disp.seg}, {4'hE, 8'h99});
    for (int n = 0; n < 37; n++) begin
      @(negedge clk);
      chk($sformatf("abort frame_done n%0d", n), disp.frame_done, (n == 36));
    end

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
